// File: rtl/router_xbar_rr.sv
// N-port frame crossbar: per-input frame FSMs, per-output round-robin arbiters
// with frame locking, registered outputs and lossless valid/backpressure.
module router_xbar_rr #(
  parameter int unsigned NumPorts = 4,
  parameter int unsigned Width    = 64,
  parameter int unsigned LenW     = 32
) (
  input  logic                           CLK,
  input  logic                           RST,
  input  logic [NumPorts-1:0][Width-1:0] D,
  input  logic [NumPorts-1:0]            D_VALID,
  output logic [NumPorts-1:0]            D_BP,
  output logic [NumPorts-1:0][Width-1:0] Q,
  output logic [NumPorts-1:0]            Q_VALID,
  input  logic [NumPorts-1:0]            Q_BP,
  output logic [NumPorts-1:0]            Q_SOF,
  output logic [NumPorts-1:0]            Q_EOF,
  output logic [LenW-1:0]                DROP_CNT
);
  localparam int unsigned PW = (NumPorts > 1) ? $clog2(NumPorts) : 1;
  typedef logic [PW-1:0] port_t;
  typedef enum logic [1:0] {IDLE, REQ, XFER, DROP} state_e;

  state_e          state_q [NumPorts];
  state_e          state_d [NumPorts];
  logic [LenW-1:0] togo_q  [NumPorts];
  logic [LenW-1:0] togo_d  [NumPorts];
  port_t           dest_q  [NumPorts];
  port_t           dest_d  [NumPorts];
  port_t           owner_q [NumPorts];
  port_t           owner_d [NumPorts];
  port_t           ptr_q   [NumPorts];
  port_t           ptr_d   [NumPorts];

  logic [NumPorts-1:0]            lock_q, lock_d, first_q, first_d;
  logic [NumPorts-1:0][Width-1:0] q_q, q_d;
  logic [NumPorts-1:0]            qv_q, qv_d, sof_q, sof_d, eof_q, eof_d;
  logic [LenW-1:0]                drop_cnt_q, drop_cnt_d;

  logic [NumPorts-1:0] good, want, granted, can_load, load;
  port_t               rdest [NumPorts];
  logic [LenW-1:0]     len   [NumPorts];

  // Route-word decode; an IDLE input with a good head requests in the same cycle
  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      good[i]  = (D[i][7:0] != 8'd0) && (D[i][7:0] <= 8'(NumPorts));
      len[i]   = LenW'(D[i][47:16]);
      rdest[i] = (state_q[i] == REQ) ? dest_q[i] : port_t'(D[i][7:0] - 8'd1);
      want[i]  = (state_q[i] == REQ) || ((state_q[i] == IDLE) && D_VALID[i] && good[i]);
    end
  end

  always_comb begin
    for (int unsigned j = 0; j < NumPorts; j++) begin
      can_load[j] = !qv_q[j] || !Q_BP[j];
      load[j]     = lock_q[j] && D_VALID[owner_q[j]] && can_load[j];
    end
  end

  always_comb begin
    int unsigned idx;
    logic        hit;
    port_t       win;
    idx     = 0;
    hit     = 1'b0;
    win     = '0;
    granted = '0;
    for (int unsigned j = 0; j < NumPorts; j++) begin
      lock_d[j]  = lock_q[j];
      owner_d[j] = owner_q[j];
      ptr_d[j]   = ptr_q[j];
      hit        = 1'b0;
      win        = '0;
      if (!lock_q[j]) begin
        for (int unsigned k = 0; k < NumPorts; k++) begin
          idx = 32'(ptr_q[j]) + k;
          if (idx >= NumPorts) idx = idx - NumPorts;
          if (!hit && want[port_t'(idx)] && (rdest[port_t'(idx)] == port_t'(j))) begin
            hit = 1'b1;
            win = port_t'(idx);
          end
        end
        if (hit) begin
          lock_d[j]    = 1'b1;
          owner_d[j]   = win;
          ptr_d[j]     = (32'(win) == NumPorts - 1) ? '0 : port_t'(win + 1'b1);
          granted[win] = 1'b1;
        end
      end else if (load[j] && (togo_q[owner_q[j]] == LenW'(1))) begin
        lock_d[j] = 1'b0;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NumPorts; i++) begin
      state_d[i] = state_q[i];
      togo_d[i]  = togo_q[i];
      dest_d[i]  = dest_q[i];
      D_BP[i]    = 1'b1;
      case (state_q[i])
        IDLE: if (D_VALID[i]) begin
          if (good[i]) begin
            dest_d[i] = rdest[i];
            if (granted[i]) begin
              state_d[i] = XFER;
              togo_d[i]  = len[i] + 1'b1;
            end else begin
              state_d[i] = REQ;
            end
          end else begin
            // Bad route word is swallowed here; LEN=0 never enters DROP
            D_BP[i] = 1'b0;
            if (len[i] != '0) begin
              state_d[i] = DROP;
              togo_d[i]  = len[i];
            end
          end
        end
        REQ: if (granted[i]) begin
          state_d[i] = XFER;
          togo_d[i]  = len[i] + 1'b1;
        end
        XFER: begin
          D_BP[i] = !can_load[dest_q[i]];
          if (D_VALID[i] && can_load[dest_q[i]]) begin
            togo_d[i] = togo_q[i] - 1'b1;
            if (togo_q[i] == LenW'(1)) state_d[i] = IDLE;
          end
        end
        DROP: begin
          D_BP[i] = 1'b0;
          if (D_VALID[i]) begin
            togo_d[i] = togo_q[i] - 1'b1;
            if (togo_q[i] == LenW'(1)) state_d[i] = IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    q_d        = q_q;
    qv_d       = qv_q;
    sof_d      = sof_q;
    eof_d      = eof_q;
    first_d    = first_q;
    drop_cnt_d = drop_cnt_q;
    for (int unsigned j = 0; j < NumPorts; j++) begin
      if (can_load[j]) begin
        qv_d[j]  = load[j];
        sof_d[j] = load[j] && first_q[j];
        eof_d[j] = load[j] && (togo_q[owner_q[j]] == LenW'(1));
        if (load[j]) q_d[j] = D[owner_q[j]];
      end
      if (!lock_q[j])   first_d[j] = 1'b1;
      else if (load[j]) first_d[j] = 1'b0;
    end
    for (int unsigned i = 0; i < NumPorts; i++) begin
      if ((state_q[i] == IDLE) && D_VALID[i] && !good[i] && (drop_cnt_d != '1))
        drop_cnt_d = drop_cnt_d + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int unsigned i = 0; i < NumPorts; i++) begin
        state_q[i] <= IDLE;
        togo_q[i]  <= '0;
        dest_q[i]  <= '0;
        owner_q[i] <= '0;
        ptr_q[i]   <= '0;
      end
      lock_q     <= '0;
      first_q    <= '1;
      q_q        <= '0;
      qv_q       <= '0;
      sof_q      <= '0;
      eof_q      <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      togo_q     <= togo_d;
      dest_q     <= dest_d;
      owner_q    <= owner_d;
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      first_q    <= first_d;
      q_q        <= q_d;
      qv_q       <= qv_d;
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign Q        = q_q;
  assign Q_VALID  = qv_q;
  assign Q_SOF    = sof_q;
  assign Q_EOF    = eof_q;
  assign DROP_CNT = drop_cnt_q;

endmodule
